mxv_cmd_frame_rx: RTL and testbench

//  UART-side command receiver/decoder for the MxV engine; the initiator the MxV control FSM answers to.

---
 rtl/mxv_cmd_frame_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_mxv_cmd_frame_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxv_cmd_frame_rx.sv
// mxv_cmd_frame_rx: framed command receiver for the MxV engine.
// Frame layout: 0xFE | LEN | CMD | payload (LEN-1 bytes) | 0xEF, LEN counts CMD+payload.
// Handshake: rx_valid is a one-cycle strobe per received byte and is never back-pressured;
// push/start/enb_CMD2/err/fifo_clr are one-cycle registered pulses, busy is a level.
module mxv_cmd_frame_rx #(
    parameter int MAX_N       = 8,
    parameter int DEFAULT_N   = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       fifo_full,
    input  logic       flag_SM_cmd_MxV,
    output logic       push,
    output logic [7:0] push_data,
    output logic       fifo_clr,
    output logic       start,
    output logic       enb_CMD2,
    output logic [3:0] n_size,
    output logic       busy,
    output logic       err,
    output logic [2:0] err_code
);

    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    HDR_BYTE  = 8'hFE;
    localparam logic [7:0]    TAIL_BYTE = 8'hEF;

    typedef enum logic [2:0] {
        WAIT_HDR, GET_LEN, GET_CMD, PAYLOAD, GET_TAIL, EXEC
    } state_t;

    typedef enum logic [1:0] {
        CMD_SETN, CMD_RESEND, CMD_LOAD
    } cmd_t;

    state_t        state;
    cmd_t          cmd_q;
    logic [7:0]    len_q;
    logic [7:0]    pay_cnt;
    logic [7:0]    setn_val;
    logic          pushed;     // at least one operand byte of this frame reached the FIFO
    logic          rej_busy;   // command arrived while busy; parse it but reject at the tail
    logic [TW-1:0] idle_cnt;

    logic [8:0]    load_len;
    logic          in_frame;
    logic          timeout_hit;
    logic          setn_ok;
    logic          fail;
    logic [2:0]    fail_code;
    logic          fail_clr;

    // Frame-level helpers: expected LOAD length, idle timeout and SET_N range.
    always_comb begin
        load_len    = 9'd1 + {5'd0, n_size} * {5'd0, n_size} + {5'd0, n_size};
        in_frame    = state inside {GET_LEN, GET_CMD, PAYLOAD, GET_TAIL};
        timeout_hit = in_frame && !rx_valid && (idle_cnt == IDLE_LAST);
        setn_ok     = (setn_val >= 8'd2) && (setn_val <= 8'(MAX_N));
    end

    // Decide whether the current cycle rejects the frame, and with which code.
    always_comb begin
        fail      = 1'b0;
        fail_code = 3'd0;
        if (timeout_hit) begin
            fail      = 1'b1;
            fail_code = 3'd4;
        end else if (rx_valid) begin
            case (state)
                GET_LEN: begin
                    if (rx_data == 8'd0) begin
                        fail      = 1'b1;
                        fail_code = 3'd1;
                    end
                end
                GET_CMD: begin
                    case (rx_data)
                        8'h01: begin
                            fail      = (len_q != 8'd2);
                            fail_code = 3'd1;
                        end
                        8'h02: begin
                            fail      = (len_q != 8'd1);
                            fail_code = 3'd1;
                        end
                        8'h03: begin
                            fail      = ({1'b0, len_q} != load_len);
                            fail_code = 3'd1;
                        end
                        default: begin
                            fail      = 1'b1;
                            fail_code = 3'd2;
                        end
                    endcase
                end
                PAYLOAD: begin
                    if (cmd_q == CMD_LOAD && !rej_busy && fifo_full) begin
                        fail      = 1'b1;
                        fail_code = 3'd6;
                    end
                end
                GET_TAIL: begin
                    if (rx_data != TAIL_BYTE) begin
                        fail      = 1'b1;
                        fail_code = 3'd3;
                    end else if (rej_busy) begin
                        fail      = 1'b1;
                        fail_code = 3'd5;
                    end else if (cmd_q == CMD_SETN && !setn_ok) begin
                        fail      = 1'b1;
                        fail_code = 3'd7;
                    end
                end
                default: ;
            endcase
        end
        fail_clr = fail && pushed;
    end

    // Inter-byte idle counter; only meaningful while a frame is open.
    always_ff @(posedge clk) begin
        if (rst || rx_valid || !in_frame) idle_cnt <= '0;
        else                               idle_cnt <= idle_cnt + 1'b1;
    end

    // Frame FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_HDR;
            cmd_q     <= CMD_SETN;
            len_q     <= 8'd0;
            pay_cnt   <= 8'd0;
            setn_val  <= 8'd0;
            pushed    <= 1'b0;
            rej_busy  <= 1'b0;
            push      <= 1'b0;
            push_data <= 8'd0;
            fifo_clr  <= 1'b0;
            start     <= 1'b0;
            enb_CMD2  <= 1'b0;
            n_size    <= 4'(DEFAULT_N);
            busy      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            push     <= 1'b0;
            fifo_clr <= 1'b0;
            start    <= 1'b0;
            enb_CMD2 <= 1'b0;
            err      <= 1'b0;
            if (busy && flag_SM_cmd_MxV) busy <= 1'b0;

            if (fail) begin
                err      <= 1'b1;
                err_code <= fail_code;
                fifo_clr <= fail_clr;
                state    <= WAIT_HDR;
            end else begin
                case (state)
                    WAIT_HDR: begin
                        if (rx_valid && rx_data == HDR_BYTE) begin
                            pushed <= 1'b0;
                            state  <= GET_LEN;
                        end
                    end
                    GET_LEN: begin
                        if (rx_valid) begin
                            len_q <= rx_data;
                            state <= GET_CMD;
                        end
                    end
                    GET_CMD: begin
                        if (rx_valid) begin
                            case (rx_data)
                                8'h01:   cmd_q <= CMD_SETN;
                                8'h02:   cmd_q <= CMD_RESEND;
                                default: cmd_q <= CMD_LOAD;
                            endcase
                            rej_busy <= busy;
                            pay_cnt  <= len_q - 8'd1;
                            state    <= (len_q == 8'd1) ? GET_TAIL : PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (rx_valid) begin
                            if (cmd_q == CMD_LOAD && !rej_busy) begin
                                push      <= 1'b1;
                                push_data <= rx_data;
                                pushed    <= 1'b1;
                            end
                            if (cmd_q == CMD_SETN) setn_val <= rx_data;
                            pay_cnt <= pay_cnt - 8'd1;
                            if (pay_cnt == 8'd1) state <= GET_TAIL;
                        end
                    end
                    GET_TAIL: begin
                        if (rx_valid) begin
                            state <= EXEC;
                            case (cmd_q)
                                CMD_LOAD: begin
                                    start <= 1'b1;
                                    busy  <= 1'b1;
                                end
                                CMD_RESEND: begin
                                    enb_CMD2 <= 1'b1;
                                    busy     <= 1'b1;
                                end
                                default: n_size <= setn_val[3:0];
                            endcase
                        end
                    end
                    EXEC:    state <= WAIT_HDR;
                    default: state <= WAIT_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mxv_cmd_frame_rx.sv
// Bench for mxv_cmd_frame_rx: frame-level reference model feeding an expected-event queue,
// with an independent monitor that checks every output pulse and its timing.
module tb_mxv_cmd_frame_rx;

  localparam int MAX_N = 8;
  localparam int DEF_N = 4;
  localparam int TO    = 300;
  localparam int W     = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       flag_SM_cmd_MxV = 1'b0;
  logic       push, fifo_clr, start, enb_CMD2, busy, err;
  logic [7:0] push_data;
  logic [3:0] n_size;
  logic [2:0] err_code;

  mxv_cmd_frame_rx #(.MAX_N(MAX_N), .DEFAULT_N(DEF_N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_full(fifo_full), .flag_SM_cmd_MxV(flag_SM_cmd_MxV),
    .push(push), .push_data(push_data), .fifo_clr(fifo_clr), .start(start),
    .enb_CMD2(enb_CMD2), .n_size(n_size), .busy(busy), .err(err), .err_code(err_code)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  last_acc = 0;
  bit  to_mode = 1'b0;
  int  m_n = DEF_N;
  bit  m_busy = 1'b0;
  logic [7:0] fr[$];

  function automatic logic [W-1:0] ev(input bit p, input bit s, input bit r,
                                      input bit e, input bit c, input logic [7:0] d);
    return {p, s, r, e, c, d};
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic exp_err(input int code, input bit clr);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, clr, 8'(code)));
  endtask

  // reference model: consumes a whole frame, returns how many bytes the receiver will take
  task automatic model_frame(input logic [7:0] f[$], input int full_at, output int nsend);
    int len, cmd, pushes, v;
    bit len_ok;
    len = f[1]; cmd = f[2]; pushes = 0; len_ok = 1'b0;
    nsend = 2;
    if (len == 0) begin exp_err(1, 1'b0); return; end
    nsend = 3;
    if (cmd == 1)      len_ok = (len == 2);
    else if (cmd == 2) len_ok = (len == 1);
    else if (cmd == 3) len_ok = (len == 1 + m_n * m_n + m_n);
    else begin exp_err(2, 1'b0); return; end
    if (!len_ok) begin exp_err(1, 1'b0); return; end
    for (int i = 0; i < len - 1; i++) begin
      if (cmd == 3 && !m_busy) begin
        if (i == full_at) begin
          exp_err(6, pushes > 0);
          nsend = 4 + i;
          return;
        end
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, f[3 + i]));
        pushes++;
      end
    end
    nsend = len + 3;
    if (f[len + 2] != 8'hEF) begin exp_err(3, pushes > 0); return; end
    if (m_busy) begin exp_err(5, 1'b0); return; end
    case (cmd)
      1: begin
        v = f[3];
        if (v >= 2 && v <= MAX_N) m_n = v;
        else exp_err(7, 1'b0);
      end
      2: begin
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        m_busy = 1'b1;
      end
      default: begin
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        m_busy = 1'b1;
      end
    endcase
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit full);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; fifo_full = full;
    @(posedge clk); #1;
    rx_valid = 1'b0; fifo_full = 1'b0;
    last_acc = cyc;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int full_at);
    int n;
    model_frame(f, full_at, n);
    if (n > f.size()) n = f.size();
    for (int i = 0; i < n; i++) send_byte(f[i], full_at >= 0 && i == 3 + full_at);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("n_size", n_size, m_n);
    check("busy", busy, m_busy);
  endtask

  task automatic mk_load(input int len, input bit rnd, input logic [7:0] tail);
    fr = {};
    fr.push_back(8'hFE); fr.push_back(8'(len)); fr.push_back(8'h03);
    for (int i = 0; i < len - 1; i++) fr.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    fr.push_back(tail);
  endtask

  task automatic pulse_flag();
    @(posedge clk); #1 flag_SM_cmd_MxV = 1'b1;
    @(negedge clk);
    check("busy_hold", busy, m_busy);
    @(posedge clk); #1 flag_SM_cmd_MxV = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    check("busy_clear", busy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
  endtask

  // monitor: every output pulse must match the next expected event, at the expected cycle
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    int lat_want;
    if (!rst && (push || start || enb_CMD2 || err || fifo_clr)) begin
      got = ev(push, start, enb_CMD2, err, fifo_clr,
               push ? push_data : (err ? {5'd0, err_code} : 8'd0));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h want none (t=%0t)", got, $time);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL event: got %h want %h (t=%0t)", got, want, $time);
        end
      end
      lat_want = to_mode ? TO : 0;
      checks++;
      if (cyc - last_acc != lat_want) begin
        errors++;
        $display("FAIL latency: got %0d want %0d (t=%0t)", cyc - last_acc, lat_want, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, len, full_at, v;
    logic [7:0] tail;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_n_size", n_size, DEF_N);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_push", push, 0);
    check("rst_start", start, 0);
    check("rst_push_data", push_data, 0);

    // LOAD N=4, then done pulse
    mk_load(21, 1'b0, 8'hEF);
    send_frame(fr, -1);
    pulse_flag();

    // SET_N legal, then out of range
    fr = '{8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h02, 8'h01, 8'h10, 8'hEF}; send_frame(fr, -1);

    // RESEND idle, then while busy
    fr = '{8'hFE, 8'h01, 8'h02, 8'hEF}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h01, 8'h02, 8'hEF}; send_frame(fr, -1);
    // LOAD while busy: parsed, nothing pushed, rejected
    mk_load(13, 1'b0, 8'hEF); send_frame(fr, -1);
    pulse_flag();

    // bad tail after full payload, FIFO overflow on byte 5
    mk_load(13, 1'b0, 8'hEE); send_frame(fr, -1);
    mk_load(13, 1'b0, 8'hEF); send_frame(fr, 4);

    // SET_N boundaries, LEN=0, unknown command, wrong LEN for RESEND
    fr = '{8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h02, 8'h01, 8'(MAX_N), 8'hEF}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h02, 8'h01, 8'(MAX_N + 1), 8'hEF}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h02, 8'h01, 8'h01, 8'hEF}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h00, 8'h01}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h01, 8'h07, 8'hEF}; send_frame(fr, -1);
    fr = '{8'hFE, 8'h02, 8'h02, 8'h00, 8'hEF}; send_frame(fr, -1);
    pulse_flag();

    // stall after LEN, then garbage, then normal frames
    to_mode = 1'b1;
    exp_err(4, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h04, 1'b0);
    repeat (TO + 10) @(posedge clk);
    to_mode = 1'b0;
    send_byte(8'h55, 1'b0);
    send_byte(8'hEF, 1'b0);
    fr = '{8'hFE, 8'h02, 8'h01, 8'h06, 8'hEF}; send_frame(fr, -1);
    mk_load(1 + m_n * m_n + m_n, 1'b1, 8'hEF); send_frame(fr, -1);
    pulse_flag();

    // randomized frame mix
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: begin
          len  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 1 + m_n * m_n + m_n;
          tail = ($urandom_range(0, 7) == 0) ? 8'hE0 : 8'hEF;
          mk_load(len, 1'b1, tail);
          full_at = (len > 1 && $urandom_range(0, 7) == 0) ? $urandom_range(0, len - 2) : -1;
          send_frame(fr, full_at);
        end
        2: begin
          v = $urandom_range(0, 15);
          fr = '{8'hFE, 8'h02, 8'h01, 8'(v), 8'hEF};
          send_frame(fr, -1);
        end
        3: begin
          fr = '{8'hFE, 8'h01, 8'h02, 8'hEF};
          send_frame(fr, -1);
        end
        4: begin
          v = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(4, 255);
          fr = '{8'hFE, 8'($urandom_range(0, 3)), 8'(v), 8'hEF};
          send_frame(fr, -1);
        end
        default: pulse_flag();
      endcase
    end
    drain();

    // reset in the middle of a frame while busy: no pulses, defaults restored
    if (!m_busy) begin
      fr = '{8'hFE, 8'h01, 8'h02, 8'hEF}; send_frame(fr, -1);
    end
    send_byte(8'hFE, 1'b0);
    send_byte(8'h02, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_n = DEF_N; m_busy = 1'b0;
    @(negedge clk);
    check("mid_rst_n_size", n_size, DEF_N);
    check("mid_rst_busy", busy, 0);
    fr = '{8'hFE, 8'h01, 8'h02, 8'hEF}; send_frame(fr, -1);
    pulse_flag();

    drain();
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
